// File: rtl/rename_pkg.sv
// rename_pkg: shared rename-stage constants and types.
// Used by the physical-register free list and the rename table.
//   NUM_AREGS / NUM_PREGS         architectural / physical register counts
//   RENAME_WIDTH / COMMIT_WIDTH   allocation / retire lanes per cycle
//   preg_t / areg_t               physical / architectural register IDs
//   ptr_add_mod()                 circular-pointer add for non-power-of-two rings
package rename_pkg;

    localparam int NUM_AREGS    = 32;
    localparam int NUM_PREGS    = 64;
    localparam int RENAME_WIDTH = 2;
    localparam int COMMIT_WIDTH = 2;

    localparam int PREG_W = $clog2(NUM_PREGS);
    localparam int AREG_W = $clog2(NUM_AREGS);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    // (ptr + inc) mod depth. Callers keep ptr < depth and inc <= depth,
    // so a single conditional subtract is enough.
    function automatic int unsigned ptr_add_mod(input int unsigned ptr,
                                                input int unsigned inc,
                                                input int unsigned depth);
        int unsigned s;
        s = ptr + inc;
        return (s >= depth) ? (s - depth) : s;
    endfunction

endpackage

// File: rtl/lane_prefix_count.sv
// lane_prefix_count: exclusive prefix popcount of an N-bit enable vector.
//   en_i      per-lane enables
//   prefix_o  lane k gets the number of set enables in lanes 0..k-1
//   total_o   popcount of en_i
module lane_prefix_count #(
    parameter  int N    = 2,
    localparam int CNTW = $clog2(N + 1)
) (
    input  logic [N-1:0]           en_i,
    output logic [N-1:0][CNTW-1:0] prefix_o,
    output logic [CNTW-1:0]        total_o
);

    logic [CNTW-1:0] acc;

    always_comb begin
        acc      = '0;
        prefix_o = '0;
        for (int k = 0; k < N; k++) begin
            prefix_o[k] = acc;
            acc         = acc + CNTW'(en_i[k]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/preg_free_list.sv
// preg_free_list: circular free list of physical register IDs.
// Allocation pops from spec_head (zero-latency, lane-compacted), retire
// advances commit_head, frees push at tail. A flush rewinds spec_head to
// commit_head, returning every unretired allocation to the free pool.
//   clk, rst       clock, synchronous active-high reset
//   alloc_req      per-lane allocation request
//   alloc_ready    at least RENAME_WIDTH entries free (registered count)
//   alloc_preg     lane-packed allocated preg IDs
//   retire_alloc   per-lane retire of an allocating instruction
//   free_en        per-lane push enable
//   free_preg      lane-packed preg IDs being pushed
//   flush          squash speculative allocations
//   free_count     registered number of free entries
module preg_free_list #(
    parameter  int NUM_AREGS    = rename_pkg::NUM_AREGS,
    parameter  int NUM_PREGS    = rename_pkg::NUM_PREGS,
    parameter  int RENAME_WIDTH = rename_pkg::RENAME_WIDTH,
    parameter  int COMMIT_WIDTH = rename_pkg::COMMIT_WIDTH,
    localparam int PW           = $clog2(NUM_PREGS),
    localparam int DEPTH        = NUM_PREGS - NUM_AREGS,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RENAME_WIDTH-1:0]    alloc_req,
    output logic                       alloc_ready,
    output logic [RENAME_WIDTH*PW-1:0] alloc_preg,
    input  logic [COMMIT_WIDTH-1:0]    retire_alloc,
    input  logic [COMMIT_WIDTH-1:0]    free_en,
    input  logic [COMMIT_WIDTH*PW-1:0] free_preg,
    input  logic                       flush,
    output logic [CW-1:0]              free_count
);
    import rename_pkg::*;

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW   = $clog2(RENAME_WIDTH + 1);
    localparam int MW   = $clog2(COMMIT_WIDTH + 1);

    logic [DEPTH-1:0][PW-1:0] entry_q;
    logic [PTRW-1:0] spec_head_q, spec_head_d;
    logic [PTRW-1:0] commit_head_q, commit_head_d;
    logic [PTRW-1:0] tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    // Allocated but not yet retired: the span commit_head..spec_head.
    logic [CW-1:0]   spec_cnt_q, spec_cnt_d;

    logic [RENAME_WIDTH-1:0][RW-1:0]   a_pre;
    logic [RW-1:0]                     a_tot;
    logic [COMMIT_WIDTH-1:0][MW-1:0]   f_pre, r_pre;
    logic [MW-1:0]                     f_tot, r_tot;
    logic [COMMIT_WIDTH-1:0][PTRW-1:0] wr_idx;
    logic [RENAME_WIDTH-1:0][PTRW-1:0] rd_idx;
    logic                              fire;
    logic [CW-1:0]                     alloc_n, free_n, ret_n;
    logic                              unused_rpre;

    lane_prefix_count #(.N(RENAME_WIDTH)) u_alloc_pc (
        .en_i(alloc_req), .prefix_o(a_pre), .total_o(a_tot));
    lane_prefix_count #(.N(COMMIT_WIDTH)) u_free_pc (
        .en_i(free_en), .prefix_o(f_pre), .total_o(f_tot));
    lane_prefix_count #(.N(COMMIT_WIDTH)) u_ret_pc (
        .en_i(retire_alloc), .prefix_o(r_pre), .total_o(r_tot));

    // Retire only needs the total; per-lane offsets are irrelevant.
    assign unused_rpre = ^r_pre;

    assign alloc_ready = (count_q >= CW'(RENAME_WIDTH));
    assign free_count  = count_q;
    assign fire        = alloc_ready && !flush && (|alloc_req);
    assign alloc_n     = fire ? CW'(a_tot) : '0;
    assign free_n      = CW'(f_tot);
    assign ret_n       = CW'(r_tot);

    // Read ports come straight off the registered array, so entries written
    // by this cycle's frees are invisible until the next cycle.
    always_comb begin
        rd_idx     = '0;
        alloc_preg = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            rd_idx[k] = PTRW'(ptr_add_mod(32'(spec_head_q), 32'(a_pre[k]), DEPTH));
            alloc_preg[k*PW +: PW] = entry_q[rd_idx[k]];
        end
    end

    always_comb begin
        wr_idx = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++)
            wr_idx[k] = PTRW'(ptr_add_mod(32'(tail_q), 32'(f_pre[k]), DEPTH));
    end

    always_comb begin
        commit_head_d = PTRW'(ptr_add_mod(32'(commit_head_q), 32'(r_tot), DEPTH));
        tail_d        = PTRW'(ptr_add_mod(32'(tail_q), 32'(f_tot), DEPTH));
        if (flush) begin
            // Everything allocated past the (post-retire) commit point returns.
            spec_head_d = commit_head_d;
            spec_cnt_d  = '0;
            count_d     = count_q + free_n + spec_cnt_q - ret_n;
        end else begin
            spec_head_d = PTRW'(ptr_add_mod(32'(spec_head_q), 32'(alloc_n), DEPTH));
            spec_cnt_d  = spec_cnt_q + alloc_n - ret_n;
            count_d     = count_q - alloc_n + free_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                entry_q[i] <= PW'(NUM_AREGS + i);
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= '0;
            count_q       <= CW'(DEPTH);
            spec_cnt_q    <= '0;
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++)
                if (free_en[k])
                    entry_q[wr_idx[k]] <= free_preg[k*PW +: PW];
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            spec_cnt_q    <= spec_cnt_d;
        end
    end

`ifndef SYNTHESIS
    // Occupied ring span (commit_head..tail) may never exceed DEPTH, and
    // retirement may never overtake spec_head.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (32'(count_q) + 32'(spec_cnt_q) + 32'(free_n) <= 32'(DEPTH) + 32'(ret_n));
            assert (ret_n <= spec_cnt_q);
        end
    end
`endif

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list with default parameters
// (32 aregs, 64 pregs, 2 rename lanes, 2 commit lanes, DEPTH = 32).
module tb_preg_free_list;

    localparam int PW = 6;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    alloc_req;
    logic          alloc_ready;
    logic [2*PW-1:0] alloc_preg;
    logic [1:0]    retire_alloc;
    logic [1:0]    free_en;
    logic [2*PW-1:0] free_preg;
    logic          flush;
    logic [CW-1:0] free_count;

    int n_tests = 0;
    int n_fail  = 0;

    preg_free_list dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_preg(alloc_preg),
        .retire_alloc(retire_alloc), .free_en(free_en), .free_preg(free_preg),
        .flush(flush), .free_count(free_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int k);
        return 32'(alloc_preg[k*PW +: PW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = '0; retire_alloc = '0; free_en = '0; free_preg = '0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] req, input int cycles);
        alloc_req = req;
        for (int i = 0; i < cycles; i++) tick();
        alloc_req = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(free_count), 32);
        chk("rst_ready", 32'(alloc_ready), 1);

        // Two-lane allocation straight after reset
        alloc_req = 2'b11; #1;
        chk("a11_lane0", lane(0), 32);
        chk("a11_lane1", lane(1), 33);
        tick(); alloc_req = '0;
        chk("a11_count", 32'(free_count), 30);

        // Lane compaction: only lane 1 requests
        do_reset();
        alloc_req = 2'b10; #1;
        chk("a10_lane1", lane(1), 32);
        tick();
        alloc_req = 2'b01; #1;
        chk("a01_lane0", lane(0), 33);
        tick(); alloc_req = '0;
        chk("a10_count", 32'(free_count), 30);

        // Drain to 1 entry: 15x2 + 1 = 31 allocations
        do_reset();
        alloc(2'b11, 15);
        alloc(2'b01, 1);
        chk("low_count", 32'(free_count), 1);
        chk("low_ready", 32'(alloc_ready), 0);
        alloc_req = 2'b11; #1;
        chk("low_lane0", lane(0), 63);
        tick(); alloc_req = '0;
        chk("low_hold", 32'(free_count), 1);
        alloc_req = 2'b01; #1;
        chk("low_ptr", lane(0), 63);
        alloc_req = '0;

        // Allocate 4, retire 2, flush (with a request that must be dropped)
        do_reset();
        alloc(2'b11, 2);
        chk("fl_pre_count", 32'(free_count), 28);
        retire_alloc = 2'b11; tick(); retire_alloc = '0;
        flush = 1'b1; alloc_req = 2'b11; tick(); flush = 1'b0; alloc_req = '0;
        chk("fl_count", 32'(free_count), 30);
        alloc_req = 2'b11; #1;
        chk("fl_lane0", lane(0), 34);
        chk("fl_lane1", lane(1), 35);
        tick(); alloc_req = '0;

        // Same-cycle free and alloc, freed IDs reappear after the wrap
        do_reset();
        alloc(2'b11, 1);
        alloc_req = 2'b11; retire_alloc = 2'b11; free_en = 2'b11;
        free_preg = {6'd40, 6'd7}; #1;
        chk("fr_lane0", lane(0), 34);
        chk("fr_lane1", lane(1), 35);
        tick(); idle();
        chk("fr_count", 32'(free_count), 30);
        alloc(2'b11, 13);
        alloc_req = 2'b11; #1;
        chk("fr_last1", lane(1), 63);
        tick();
        #1;
        chk("wrap_lane0", lane(0), 7);
        chk("wrap_lane1", lane(1), 40);
        tick(); alloc_req = '0;
        chk("wrap_empty", 32'(alloc_ready), 0);

        // Reset overrides flush/free/alloc/retire in the same cycle
        do_reset();
        alloc(2'b11, 2);
        rst = 1'b1; flush = 1'b1; free_en = 2'b11; free_preg = {6'd9, 6'd10};
        alloc_req = 2'b11; retire_alloc = 2'b11;
        tick();
        rst = 1'b0; idle();
        chk("mrst_count", 32'(free_count), 32);
        chk("mrst_ready", 32'(alloc_ready), 1);
        alloc_req = 2'b11; #1;
        chk("mrst_lane0", lane(0), 32);
        chk("mrst_lane1", lane(1), 33);
        tick(); alloc_req = '0;
        chk("mrst_after", 32'(free_count), 30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/preg_free_list.md
PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 Param NUM_AREGS, default 32, number of architectural registers.
REQ-002 Param NUM_PREGS, default 64, number of physical registers; NUM_PREGS > NUM_AREGS.
REQ-003 Param RENAME_WIDTH, default 2, allocation lanes per cycle.
REQ-004 Param COMMIT_WIDTH, default 2, retire/free lanes per cycle.
REQ-005 clk  input  1  clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 alloc_req  input  RENAME_WIDTH  per-lane request for a new destination preg.
REQ-008 alloc_ready  output  1  free list holds at least RENAME_WIDTH entries.
REQ-009 alloc_preg  output  RENAME_WIDTH*PW  flat lane-packed new preg IDs, lane k at bits [(k+1)*PW-1 : k*PW]; PW = clog2(NUM_PREGS).
REQ-010 retire_alloc  input  COMMIT_WIDTH  per-lane: a retiring instruction that had allocated a preg.
REQ-011 free_en  input  COMMIT_WIDTH  per-lane: push free_preg lane back to the list.
REQ-012 free_preg  input  COMMIT_WIDTH*PW  flat lane-packed pregs being released (previous mappings of retired destinations).
REQ-013 flush  input  1  squash all speculative allocations.
REQ-014 free_count  output  clog2(DEPTH+1)  current number of free entries.

Function
REQ-015 Storage is a circular queue of DEPTH = NUM_PREGS - NUM_AREGS preg IDs with spec_head, commit_head, tail pointers; pointers wrap modulo DEPTH (DEPTH need not be a power of two).
REQ-016 alloc_ready is 1 iff free_count >= RENAME_WIDTH, using registered count only, with no dependence on alloc_req.
REQ-017 Allocation fires iff alloc_ready && !flush && |alloc_req; it is all-or-nothing across lanes.
REQ-018 Lanes are compacted: lane k drives entry[spec_head + number of requesting lanes below k], combinationally in the same cycle (zero latency); non-requesting lanes' alloc_preg values are don't-care.
REQ-019 On fire, spec_head advances by popcount(alloc_req) at the next edge.
REQ-020 Each free_en lane writes its free_preg at tail + (number of enabled free lanes below it), and tail advances by popcount(free_en).
REQ-021 commit_head advances by popcount(retire_alloc) each cycle, including flush cycles.
REQ-022 On flush, spec_head becomes the commit_head value that includes that cycle's retire_alloc advance, and any same-cycle allocation is discarded.
REQ-023 free_count updates next edge to (entries from new spec_head to new tail), equivalently old count - allocated + freed, with flush restoring the squashed entries.
REQ-024 Registers freed in cycle N are allocatable no earlier than cycle N+1.
REQ-025 Allocation when free_count < RENAME_WIDTH never occurs, even if fewer lanes request.
REQ-026 Pushing beyond DEPTH entries, or retiring past spec_head, is a protocol violation flagged by a simulation assertion; the RTL behaviour is undefined.

Reset
REQ-027 On rst, entry i = NUM_AREGS + i for i in 0..DEPTH-1, matching the identity reset mapping of the rename table.
REQ-028 On rst, spec_head = commit_head = 0 and tail = 0 (full queue, count = DEPTH), free_count = DEPTH, and alloc_ready = 1.
REQ-029 rst overrides flush, alloc, retire and free in the same cycle.

Structure
REQ-030 NUM_AREGS, NUM_PREGS, RENAME_WIDTH, COMMIT_WIDTH, preg_t and areg_t belong in shared package rename_pkg, which the rename table also uses.
REQ-031 One sub-module, lane_prefix_count, computes the exclusive prefix popcount and total of an N-bit enable vector; it is instantiated for alloc_req, free_en and retire_alloc.
REQ-032 Pointer add-mod-DEPTH is a package function.

Verification (NUM_AREGS=32, NUM_PREGS=64, widths 2)
REQ-033 Reset then alloc_req=2'b11 -> alloc_preg lanes {33,32}, next cycle free_count=30.
REQ-034 alloc_req=2'b10 after reset -> lane1 = 32, spec_head advances by 1, next alloc lane0 = 33.
REQ-035 Allocate 31 pregs -> free_count=1 and alloc_ready=0; alloc_req is ignored and pointers hold.
REQ-036 Allocate 4, retire_alloc 2 of them, then flush -> free_count=30 and the next alloc returns the 3rd and 4th squashed IDs (34,35).
REQ-037 Free lanes 2'b11 with {40,7} in the same cycle as an alloc -> the freed entries are not returned that cycle; they appear in order 7,40 after the queue wraps.
REQ-038 Assert rst mid-stream with flush=1 and free_en=2'b11 -> the reset state of REQ-027 and REQ-028 holds exactly the next cycle.
